// File: rtl/store_buffer.sv
// Word store buffer between the MEM stage and data memory: queues stores, drains one per idle cycle,
// forwards loads from the youngest matching entry. Define STORE_BUF_COALESCE_EN to merge same-word stores.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       st_valid_i,
  input  logic [ADDR_W-1:0]          st_addr_i,
  input  logic [DATA_W-1:0]          st_data_i,
  output logic                       st_ready_o,
  input  logic                       ld_valid_i,
  input  logic [ADDR_W-1:0]          ld_addr_i,
  output logic [DATA_W-1:0]          ld_data_o,
  output logic                       ld_hit_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  output logic [DATA_W-1:0]          mem_data_o,
  output logic                       mem_write_o,
  output logic                       mem_read_o,
  input  logic [DATA_W-1:0]          mem_rdata_i,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WA_W  = ADDR_W - 2;

  typedef logic [PTR_W-1:0] ptr_t;

  logic [WA_W-1:0]   r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  ptr_t              r_head;
  ptr_t              r_tail;
  logic [CNT_W-1:0]  r_count;

  logic [WA_W-1:0]   w_st_wa;
  logic [WA_W-1:0]   w_ld_wa;
  ptr_t              w_young;
  ptr_t              w_scan;
  logic              w_hit;
  logic [DATA_W-1:0] w_fwd_data;
  logic              w_drain;
  logic              w_st_ready;
  logic              w_coal_match;
  logic              w_coal_wr;
  logic              w_alloc;
  logic              w_unused;

  assign w_st_wa  = st_addr_i[ADDR_W-1:2];
  assign w_ld_wa  = ld_addr_i[ADDR_W-1:2];
  assign w_young  = r_tail - ptr_t'(1);
  assign w_unused = ^{st_addr_i[1:0], ld_addr_i[1:0]};

  // Scan oldest to youngest so the last match is the youngest store.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_hit      = 1'b0;
    w_fwd_data = '0;
    w_scan     = r_head;
    for (int i = 0; i < DEPTH; i++) begin
      w_scan = r_head + ptr_t'(i);
      if (r_valid[w_scan] && (r_addr[w_scan] == w_ld_wa)) begin
        w_hit      = 1'b1;
        w_fwd_data = r_data[w_scan];
      end
    end
    if (rst_i || !ld_valid_i) w_hit = 1'b0;
  end

  always_comb begin
    w_drain      = !rst_i && (r_count != '0) && !ld_valid_i;
    w_st_ready   = (r_count < CNT_W'(DEPTH));
    w_coal_match = 1'b0;
`ifdef STORE_BUF_COALESCE_EN
    // A head that is leaving this cycle cannot absorb the store.
    w_coal_match = (r_count != '0) && r_valid[w_young] && (r_addr[w_young] == w_st_wa) &&
                   !(w_drain && (r_count == CNT_W'(1)));
    if (w_coal_match) w_st_ready = 1'b1;
`endif
    if (rst_i) w_st_ready = 1'b1;
    w_coal_wr = !rst_i && st_valid_i && w_coal_match;
    w_alloc   = !rst_i && st_valid_i && w_st_ready && !w_coal_match;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_drain) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + ptr_t'(1);
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + ptr_t'(1);
      end
      r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_drain);
    end
  end

  // NOTE: entry payload is not reset; the valid bits alone decide whether an entry is live.
  always_ff @(posedge clk_i) begin
    if (w_alloc) begin
      r_addr[r_tail] <= w_st_wa;
      r_data[r_tail] <= st_data_i;
    end else if (w_coal_wr) begin
      r_data[w_young] <= st_data_i;
    end
  end

  assign st_ready_o  = w_st_ready;
  assign ld_hit_o    = w_hit;
  assign ld_data_o   = w_hit ? w_fwd_data : mem_rdata_i;
  assign mem_read_o  = ld_valid_i;
  assign mem_write_o = w_drain;
  assign mem_addr_o  = ld_valid_i ? {w_ld_wa, 2'b00} :
                       w_drain    ? {r_addr[r_head], 2'b00} : '0;
  assign mem_data_o  = w_drain ? r_data[r_head] : '0;
  assign empty_o     = rst_i || (r_count == '0);
  assign count_o     = rst_i ? '0 : r_count;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, drain, fill/forward, miss, full-reject and streaming wrap.
module tb_store_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        st_valid_i;
  logic [31:0] st_addr_i;
  logic [31:0] st_data_i;
  logic        st_ready_o;
  logic        ld_valid_i;
  logic [31:0] ld_addr_i;
  logic [31:0] ld_data_o;
  logic        ld_hit_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_write_o;
  logic        mem_read_o;
  logic [31:0] mem_rdata_i;
  logic        empty_o;
  logic [2:0]  count_o;

  int checks = 0;
  int errors = 0;

  store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .st_valid_i(st_valid_i), .st_addr_i(st_addr_i), .st_data_i(st_data_i), .st_ready_o(st_ready_o),
    .ld_valid_i(ld_valid_i), .ld_addr_i(ld_addr_i), .ld_data_o(ld_data_o), .ld_hit_o(ld_hit_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_write_o(mem_write_o),
    .mem_read_o(mem_read_o), .mem_rdata_i(mem_rdata_i),
    .empty_o(empty_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drain_all(input string tag);
    for (int i = 0; i < 10 && !empty_o; i++) tick();
    settle();
    chk(tag, {31'd0, empty_o}, 32'd1);
  endtask

  initial begin
    rst_i = 1'b1; st_valid_i = 1'b0; st_addr_i = '0; st_data_i = '0;
    ld_valid_i = 1'b0; ld_addr_i = '0; mem_rdata_i = 32'h1234_5678;
    tick(); tick(); settle();
    chk("rst_ready", {31'd0, st_ready_o}, 32'd1);
    chk("rst_empty", {31'd0, empty_o}, 32'd1);
    chk("rst_count", {29'd0, count_o}, 32'd0);
    chk("rst_write", {31'd0, mem_write_o}, 32'd0);

    // 1. Reset with stores pending
    tick();
    rst_i = 1'b0; ld_valid_i = 1'b1; ld_addr_i = 32'h40;
    st_valid_i = 1'b1; st_addr_i = 32'h100; st_data_i = 32'h11;
    tick();
    st_addr_i = 32'h104; st_data_i = 32'h22;
    tick(); settle();
    chk("t1_count2", {29'd0, count_o}, 32'd2);
    rst_i = 1'b1; st_valid_i = 1'b0; ld_valid_i = 1'b0; settle();
    chk("t1_inrst_write", {31'd0, mem_write_o}, 32'd0);
    chk("t1_inrst_count", {29'd0, count_o}, 32'd0);
    chk("t1_inrst_hit", {31'd0, ld_hit_o}, 32'd0);
    tick();
    rst_i = 1'b0; settle();
    chk("t1_post_empty", {31'd0, empty_o}, 32'd1);
    chk("t1_post_write", {31'd0, mem_write_o}, 32'd0);

    // 2. Single store drains next cycle
    st_valid_i = 1'b1; st_addr_i = 32'h10; st_data_i = 32'hDEAD_BEEF; settle();
    chk("t2_ready", {31'd0, st_ready_o}, 32'd1);
    chk("t2_nowrite", {31'd0, mem_write_o}, 32'd0);
    tick();
    st_valid_i = 1'b0; settle();
    chk("t2_write", {31'd0, mem_write_o}, 32'd1);
    chk("t2_addr", mem_addr_o, 32'h10);
    chk("t2_data", mem_data_o, 32'hDEAD_BEEF);
    chk("t2_read", {31'd0, mem_read_o}, 32'd0);
    tick(); settle();
    chk("t2_empty", {31'd0, empty_o}, 32'd1);
    chk("t2_idle_write", {31'd0, mem_write_o}, 32'd0);

    // 3. Fill under a blocking load, forward, then drain in order
    ld_valid_i = 1'b1; ld_addr_i = 32'h40;
    for (int k = 0; k < 4; k++) begin
      st_valid_i = 1'b1; st_addr_i = 32'(4 * k); st_data_i = 32'hA0 + 32'(k); settle();
      chk("t3_blocked_write", {31'd0, mem_write_o}, 32'd0);
      tick();
    end
    st_valid_i = 1'b0; settle();
    chk("t3_count", {29'd0, count_o}, 32'd4);
    chk("t3_not_ready", {31'd0, st_ready_o}, 32'd0);
    chk("t3_read", {31'd0, mem_read_o}, 32'd1);
    chk("t3_ld_addr", mem_addr_o, 32'h40);
    ld_addr_i = 32'h0B; settle();
    chk("t3_fwd_hit", {31'd0, ld_hit_o}, 32'd1);
    chk("t3_fwd_data", ld_data_o, 32'hA2);
    chk("t3_fwd_addr", mem_addr_o, 32'h08);

    // 5. Miss while non-empty
    ld_addr_i = 32'h30; settle();
    chk("t5_hit", {31'd0, ld_hit_o}, 32'd0);
    chk("t5_data", ld_data_o, 32'h1234_5678);
    chk("t5_read", {31'd0, mem_read_o}, 32'd1);
    chk("t5_write", {31'd0, mem_write_o}, 32'd0);

    ld_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("t3_drain_write", {31'd0, mem_write_o}, 32'd1);
      chk("t3_drain_addr", mem_addr_o, 32'(4 * k));
      chk("t3_drain_data", mem_data_o, 32'hA0 + 32'(k));
      tick();
    end
    settle();
    chk("t3_empty", {31'd0, empty_o}, 32'd1);

    // 4. Same-word stores, forwarding of youngest
    ld_valid_i = 1'b1; ld_addr_i = 32'h50;
    st_valid_i = 1'b1; st_addr_i = 32'h20; st_data_i = 32'd1;
    tick();
    st_data_i = 32'd2; ld_addr_i = 32'h20; settle();
    chk("t4_same_cycle_data", ld_data_o, 32'd1);
    tick();
    st_valid_i = 1'b0; ld_addr_i = 32'h22; settle();
    chk("t4_hit", {31'd0, ld_hit_o}, 32'd1);
    chk("t4_data", ld_data_o, 32'd2);
`ifdef STORE_BUF_COALESCE_EN
    chk("t4_count", {29'd0, count_o}, 32'd1);
`else
    chk("t4_count", {29'd0, count_o}, 32'd2);
`endif
    ld_valid_i = 1'b0; settle();
    chk("t4_first_addr", mem_addr_o, 32'h20);
`ifdef STORE_BUF_COALESCE_EN
    chk("t4_first_data", mem_data_o, 32'd2);
`else
    chk("t4_first_data", mem_data_o, 32'd1);
`endif
    drain_all("t4_drained");

    // 6. Full buffer: store rejected even while draining
    ld_valid_i = 1'b1; ld_addr_i = 32'h40;
    for (int k = 0; k < 4; k++) begin
      st_valid_i = 1'b1; st_addr_i = 32'h100 + 32'(4 * k); st_data_i = 32'hB0 + 32'(k);
      tick();
    end
    ld_valid_i = 1'b0; st_addr_i = 32'h200; st_data_i = 32'hFF; settle();
    chk("t6_reject_ready", {31'd0, st_ready_o}, 32'd0);
    chk("t6_drain_write", {31'd0, mem_write_o}, 32'd1);
    chk("t6_drain_addr", mem_addr_o, 32'h100);
    tick();
    st_valid_i = 1'b0; settle();
    chk("t6_count3", {29'd0, count_o}, 32'd3);
    chk("t6_next_addr", mem_addr_o, 32'h104);
    chk("t6_next_data", mem_data_o, 32'hB1);
    drain_all("t6_drained");

    // Streaming: enqueue and drain every cycle across 3*DEPTH stores
    for (int k = 0; k < 12; k++) begin
      st_valid_i = 1'b1; st_addr_i = 32'h300 + 32'(4 * k); st_data_i = 32'hC00 + 32'(k); settle();
      if (k > 0) begin
        chk("wrap_write", {31'd0, mem_write_o}, 32'd1);
        chk("wrap_addr", mem_addr_o, 32'h300 + 32'(4 * (k - 1)));
        chk("wrap_data", mem_data_o, 32'hC00 + 32'(k - 1));
        chk("wrap_count", {29'd0, count_o}, 32'd1);
      end
      tick();
    end
    st_valid_i = 1'b0; settle();
    chk("wrap_last_addr", mem_addr_o, 32'h32C);
    chk("wrap_last_data", mem_data_o, 32'hC0B);
    tick(); settle();
    chk("wrap_empty", {31'd0, empty_o}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
